sevenseg_scan_decoder: RTL and testbench

SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

---
 rtl/sevenseg_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Recovers a 4-digit hex value by watching a multiplexed, active-low seven-segment display.
// Latency: an accepted pattern reaches value/valid or err one cycle after the accept edge.

module sevenseg_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   output logic [15:0] value,
   output logic [3:0]  blank_mask,
   output logic        valid,
   output logic        err,
   output logic [1:0]  err_digit
);

   localparam logic [0:0] SETTLE = 1'b0;
   localparam logic [0:0] HELD   = 1'b1;
   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   // Sample stage and the sample before it; the pin pair is compared as one word.
   logic [6:0]  smp_seg;
   logic [3:0]  smp_an;
   logic [6:0]  prv_seg;
   logic [3:0]  prv_an;
   logic [7:0]  cnt;
   logic [0:0]  state;

   logic        same;
   logic        selectable;
   logic [1:0]  sel_idx;
   logic [3:0]  dec_nib;
   logic        dec_blank;
   logic        dec_bad;

   logic        acc_vld;
   logic [1:0]  acc_idx;
   logic [3:0]  acc_nib;
   logic        acc_blank;
   logic        acc_bad;

   logic [15:0] digits;
   logic [3:0]  blanks;
   logic [3:0]  seen;
   logic [15:0] digits_nxt;
   logic [3:0]  blanks_nxt;
   logic [3:0]  seen_nxt;

   assign same = ({smp_an, smp_seg} == {prv_an, prv_seg});

   always_comb begin
      selectable = 1'b1;
      sel_idx    = 2'd0;
      case (smp_an)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: selectable = 1'b0;
      endcase
   end

   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_bad   = 1'b0;
      case (smp_seg)
         7'h40: dec_nib = 4'h0;
         7'h79: dec_nib = 4'h1;
         7'h24: dec_nib = 4'h2;
         7'h30: dec_nib = 4'h3;
         7'h19: dec_nib = 4'h4;
         7'h12: dec_nib = 4'h5;
         7'h02: dec_nib = 4'h6;
         7'h78: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h18: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h03: dec_nib = 4'hB;
         7'h46: dec_nib = 4'hC;
         7'h21: dec_nib = 4'hD;
         7'h06: dec_nib = 4'hE;
         7'h0E: dec_nib = 4'hF;
         7'h7F: dec_blank = 1'b1;
         default: dec_bad = 1'b1;
      endcase
   end

   // Stability counter: a pair is accepted once, on the cycle its run length reaches STABLE_CYCLES.
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_seg   <= 7'h7F;
         smp_an    <= 4'hF;
         prv_seg   <= 7'h7F;
         prv_an    <= 4'hF;
         cnt       <= 8'd0;
         state     <= SETTLE;
         acc_vld   <= 1'b0;
         acc_idx   <= 2'd0;
         acc_nib   <= 4'h0;
         acc_blank <= 1'b0;
         acc_bad   <= 1'b0;
      end else begin
         smp_seg <= seg_n;
         smp_an  <= an_n;
         prv_seg <= smp_seg;
         prv_an  <= smp_an;
         acc_vld <= 1'b0;
         if (!selectable) begin
            state <= SETTLE;
            cnt   <= 8'd0;
         end else if (!same) begin
            state <= SETTLE;
            cnt   <= 8'd1;
         end else if (state == HELD) begin
            cnt <= STABLE_MAX;
         end else if (cnt >= STABLE_MAX - 8'd1) begin
            state     <= HELD;
            cnt       <= STABLE_MAX;
            acc_vld   <= 1'b1;
            acc_idx   <= sel_idx;
            acc_nib   <= dec_nib;
            acc_blank <= dec_blank;
            acc_bad   <= dec_bad;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   always_comb begin
      digits_nxt = digits;
      blanks_nxt = blanks;
      seen_nxt   = seen;
      digits_nxt[{acc_idx, 2'b00} +: 4] = acc_nib;
      blanks_nxt[acc_idx] = acc_blank;
      seen_nxt[acc_idx]   = 1'b1;
   end

   // Frame assembly: the frame publishes as soon as all four digits have been seen since the last publish/error.
   always_ff @(posedge clk) begin
      if (reset) begin
         digits     <= 16'h0000;
         blanks     <= 4'b0000;
         seen       <= 4'b0000;
         value      <= 16'h0000;
         blank_mask <= 4'b0000;
         valid      <= 1'b0;
         err        <= 1'b0;
         err_digit  <= 2'd0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (acc_vld) begin
            if (acc_bad) begin
               err       <= 1'b1;
               err_digit <= acc_idx;
               seen      <= 4'b0000;
            end else begin
               digits <= digits_nxt;
               blanks <= blanks_nxt;
               if (seen_nxt == 4'b1111) begin
                  value      <= digits_nxt;
                  blank_mask <= blanks_nxt;
                  valid      <= 1'b1;
                  seen       <= 4'b0000;
               end else begin
                  seen <= seen_nxt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed scans of the display pins, checked every cycle against a run-length model of the scanner.

module tb_sevenseg_scan_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  seg_n = 7'h7F;
   logic [3:0]  an_n = 4'hF;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic        valid;
   logic        err;
   logic [1:0]  err_digit;

   sevenseg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk),
      .reset(reset),
      .seg_n(seg_n),
      .an_n(an_n),
      .value(value),
      .blank_mask(blank_mask),
      .valid(valid),
      .err(err),
      .err_digit(err_digit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int valid_cyc = -1;
   int err_cyc = -1;
   bit live = 1'b0;

   // Model state: last sample, its run length, and the frame bookkeeping.
   logic [10:0] m_last = 11'h7FF;
   int          m_run = 1;
   bit          m_pend = 1'b0;
   logic [10:0] m_pend_smp = 11'h7FF;
   logic [15:0] m_dig = 16'h0;
   logic [3:0]  m_blk = 4'h0;
   logic [3:0]  m_seen = 4'h0;
   logic [15:0] exp_value = 16'h0;
   logic [3:0]  exp_blank = 4'h0;
   logic        exp_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic [1:0]  exp_err_digit = 2'd0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // 0..15 = hex digit, 16 = blank, -1 = undecodable
   function automatic int seg_to_nib(input logic [6:0] s);
      if (s == 7'h7F) return 16;
      for (int i = 0; i < 16; i++)
         if (seg_tbl[i] == s) return i;
      return -1;
   endfunction

   function automatic int an_index(input logic [3:0] a);
      int zeros = 0;
      int idx = -1;
      for (int i = 0; i < 4; i++)
         if (!a[i]) begin
            zeros++;
            idx = i;
         end
      return (zeros == 1) ? idx : -1;
   endfunction

   task automatic model_step();
      int idx;
      int nib;
      logic [10:0] cur;
      cyc++;
      if (reset) begin
         live = 1'b1;
         m_last = 11'h7FF; m_run = 1; m_pend = 1'b0;
         m_dig = 16'h0; m_blk = 4'h0; m_seen = 4'h0;
         exp_value = 16'h0; exp_blank = 4'h0;
         exp_valid = 1'b0; exp_err = 1'b0; exp_err_digit = 2'd0;
      end else begin
         exp_valid = 1'b0;
         exp_err = 1'b0;
         if (m_pend) begin
            idx = an_index(m_pend_smp[10:7]);
            nib = seg_to_nib(m_pend_smp[6:0]);
            if (nib < 0) begin
               exp_err = 1'b1;
               exp_err_digit = idx[1:0];
               m_seen = 4'h0;
            end else begin
               m_dig[idx*4 +: 4] = (nib == 16) ? 4'h0 : nib[3:0];
               m_blk[idx] = (nib == 16);
               m_seen[idx] = 1'b1;
               if (m_seen == 4'hF) begin
                  exp_value = m_dig;
                  exp_blank = m_blk;
                  exp_valid = 1'b1;
                  m_seen = 4'h0;
               end
            end
         end
         // A selectable pair is taken exactly when its run of identical samples reaches STABLE.
         m_pend = (m_run == STABLE) && (an_index(m_last[10:7]) >= 0);
         m_pend_smp = m_last;
         cur = {an_n, seg_n};
         if (cur == m_last) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_last = cur;
            m_run = 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (live) begin
         check("value", 32'(value), 32'(exp_value));
         check("blank_mask", 32'(blank_mask), 32'(exp_blank));
         check("valid", 32'(valid), 32'(exp_valid));
         check("err", 32'(err), 32'(exp_err));
         check("err_digit", 32'(err_digit), 32'(exp_err_digit));
         if (valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
         if (err === 1'b1) begin n_err++; err_cyc = cyc; end
      end
   end

   task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n = a;
      seg_n = s;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      show(4'hF, 7'h7F, n);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   int v0;
   int e0;
   int start;

   initial begin
      do_reset(3);
      check("rst_value", 32'(value), 32'h0);
      check("rst_blank", 32'(blank_mask), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_err_digit", 32'(err_digit), 32'h0);
      idle(4);

      // Plain scan; the last digit also measures accept-to-valid latency.
      v0 = n_valid; e0 = n_err;
      show(4'hE, 7'h30, 6); show(4'hD, 7'h19, 6); show(4'hB, 7'h12, 6);
      start = cyc;
      show(4'h7, 7'h02, 6);
      idle(6);
      check("scan_valid_count", 32'(n_valid - v0), 32'd1);
      check("scan_err_count", 32'(n_err - e0), 32'd0);
      check("scan_value", 32'(value), 32'h6543);
      check("scan_blank", 32'(blank_mask), 32'h0);
      check("valid_latency", 32'(valid_cyc - start), 32'd6);

      // Blank digit 2.
      v0 = n_valid;
      show(4'hE, 7'h30, 6); show(4'hD, 7'h19, 6); show(4'hB, 7'h7F, 6); show(4'h7, 7'h02, 6);
      idle(6);
      check("blank_valid_count", 32'(n_valid - v0), 32'd1);
      check("blank_value", 32'(value), 32'h6043);
      check("blank_mask", 32'(blank_mask), 32'h4);

      // Undecodable pattern on digit 1, then a clean scan.
      v0 = n_valid; e0 = n_err;
      show(4'hE, 7'h30, 6);
      start = cyc;
      show(4'hD, 7'h7E, 6);
      idle(6);
      check("bad_err_count", 32'(n_err - e0), 32'd1);
      check("bad_err_digit", 32'(err_digit), 32'd1);
      check("bad_err_latency", 32'(err_cyc - start), 32'd6);
      check("bad_valid_count", 32'(n_valid - v0), 32'd0);
      check("bad_value_held", 32'(value), 32'h6043);
      show(4'hE, 7'h79, 6); show(4'hD, 7'h24, 6); show(4'hB, 7'h30, 6); show(4'h7, 7'h19, 6);
      idle(6);
      check("recover_valid_count", 32'(n_valid - v0), 32'd1);
      check("recover_value", 32'(value), 32'h4321);
      check("recover_blank", 32'(blank_mask), 32'h0);

      // Reset after three accepted digits discards them.
      v0 = n_valid; e0 = n_err;
      show(4'hE, 7'h30, 6); show(4'hD, 7'h19, 6); show(4'hB, 7'h12, 6);
      do_reset(2);
      show(4'h7, 7'h02, 6);
      idle(8);
      check("rst_mid_valid_count", 32'(n_valid - v0), 32'd0);
      check("rst_mid_err_count", 32'(n_err - e0), 32'd0);
      check("rst_mid_value", 32'(value), 32'h0);

      // Digit 0 shown for fewer than STABLE cycles.
      v0 = n_valid;
      show(4'hE, 7'h40, 3);
      show(4'hD, 7'h19, 6); show(4'hB, 7'h12, 6); show(4'h7, 7'h02, 6);
      idle(8);
      check("glitch_valid_count", 32'(n_valid - v0), 32'd0);
      check("glitch_value", 32'(value), 32'h0);

      // Multiple or no digits enabled.
      v0 = n_valid; e0 = n_err;
      show(4'hC, 7'h40, 10);
      show(4'hF, 7'h40, 10);
      idle(4);
      check("multi_valid_count", 32'(n_valid - v0), 32'd0);
      check("multi_err_count", 32'(n_err - e0), 32'd0);

      // Remaining table entries.
      do_reset(2);
      v0 = n_valid;
      show(4'hE, 7'h03, 6); show(4'hD, 7'h21, 6); show(4'hB, 7'h46, 6); show(4'h7, 7'h0E, 6);
      idle(6);
      check("hex_value_a", 32'(value), 32'hFCDB);
      show(4'h7, 7'h06, 6); show(4'hB, 7'h18, 6); show(4'hD, 7'h00, 6); show(4'hE, 7'h78, 6);
      idle(6);
      check("hex_value_b", 32'(value), 32'hE987);
      check("hex_valid_count", 32'(n_valid - v0), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
